iter_div: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider with valid/ready handshakes on both sides. Successor to the fixed-latency 32-bit unsigned divider model.
- Adds per-operation signed/unsigned mode, back-pressure, flush/abort, and a divide-by-zero fast path.
- Sits beside the multiplier in the execute-stage MDU and is synthesisable as real RTL, not simulation-only.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 23 ++
 rtl/iter_div.sv | 143 ++++++++++++++
 tb/tb_iter_div.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: FSM state encoding,
// request/response records at the default MDU width, and the counter-width helper.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

  typedef struct packed {
    logic                 is_signed;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
  } div_req_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;
  } div_rsp_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;

  // The compare is WIDTH+1 bits so divisors with the MSB set still work; when
  // it succeeds the true difference is below the divisor, so WIDTH bits suffice.
  assign rem_sh   = {rem, dvd_msb};
  assign qbit     = (rem_sh >= {1'b0, dvs});
  assign rem_diff = rem_sh[WIDTH-1:0] - dvs;
  assign rem_next = qbit ? rem_diff : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/iter_div.sv
// Multi-cycle radix-2 restoring divider with signed/unsigned mode, flush and a
// divide-by-zero fast path. Handshakes: a transfer happens on a rising edge where valid & ready.
module iter_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = div_cnt_w(WIDTH)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_e       dbg_state
);

  div_state_e       state_q, state_d;
  // qd_q holds the dividend, shifting out MSB-first while quotient bits shift in.
  logic [WIDTH-1:0] qd_q, qd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  assign in_ready  = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign quotient  = qd_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state = state_q;

  assign dvd_neg = sgn_q & qd_q[WIDTH-1];
  assign dvs_neg = sgn_q & dvs_q[WIDTH-1];
  assign dvd_abs = dvd_neg ? -qd_q : qd_q;
  assign dvs_abs = dvs_neg ? -dvs_q : dvs_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (qd_q[WIDTH-1]),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    qd_d    = qd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          qd_d    = dividend;
          dvs_d   = divisor;
          sgn_d   = in_signed;
          dbz_d   = 1'b0;
          state_d = PREP;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      PREP: begin
        if (dvs_q == '0) begin
          rem_d   = qd_q;
          qd_d    = '1;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          qd_d    = dvd_abs;
          dvs_d   = dvs_abs;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        qd_d  = {qd_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (q_neg_q) qd_d = -qd_q;
        if (r_neg_q) rem_d = -rem_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      qd_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qd_q    <= qd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div at WIDTH=32: arithmetic cases, latency,
// back-pressure, back-to-back accept, flush and asynchronous reset.
module tb_iter_div;
  import div_pkg::*;

  logic        aclk;
  logic        areset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  div_state_e  dbg_state;

  int n_checks;
  int n_fail;

  iter_div #(.WIDTH(32)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Accepts one request from IDLE and waits (bounded) for out_valid; the
  // result is left held. lat is the edge count after the accept edge, -1 on timeout.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic z);
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge aclk); #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    in_signed = 1'($urandom_range(0, 1));
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge aclk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge aclk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    n_checks++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%0b exp=0", div_by_zero); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] q, r; logic z;
    run_op(1'b0, 32'd100, 32'd7, lat, q, r, z);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL unsigned_latency got=%0d exp=34", lat); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL unsigned_q got=%h exp=%h", q, 32'd14); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL unsigned_r got=%h exp=%h", r, 32'd2); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL unsigned_dbz got=%0b exp=0", z); end
    retire();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unsigned_retire_valid got=%0b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unsigned_retire_ready got=%0b exp=1", in_ready); end
    run_op(1'b0, 32'd7, 32'd100, lat, q, r, z);
    n_checks++; if (q !== 32'd0 || r !== 32'd7) begin n_fail++; $display("FAIL unsigned_small got q=%h r=%h exp q=0 r=7", q, r); end
    retire();
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, lat, q, r, z);
    n_checks++; if (q !== 32'd1 || r !== 32'd1) begin n_fail++; $display("FAIL unsigned_big_dvs got q=%h r=%h exp q=1 r=1", q, r); end
    retire();
  endtask

  task automatic test_signed();
    int lat; logic [31:0] q, r; logic z;
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, lat, q, r, z);
    n_checks++; if (q !== 32'hFFFFFFF2 || r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL signed_neg_dvd got q=%h r=%h exp q=fffffff2 r=fffffffe", q, r); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL signed_latency got=%0d exp=34", lat); end
    retire();
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, lat, q, r, z);
    n_checks++; if (q !== 32'hFFFFFFF2 || r !== 32'd2) begin n_fail++; $display("FAIL signed_neg_dvs got q=%h r=%h exp q=fffffff2 r=2", q, r); end
    retire();
    run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, lat, q, r, z);
    n_checks++; if (q !== 32'd14 || r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL signed_both_neg got q=%h r=%h exp q=e r=fffffffe", q, r); end
    retire();
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] q, r; logic z;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, q, r, z);
    n_checks++; if (q !== 32'h80000000 || r !== 32'h0 || z !== 1'b0) begin n_fail++; $display("FAIL ovf_signed got q=%h r=%h z=%0b exp q=80000000 r=0 z=0", q, r, z); end
    retire();
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, q, r, z);
    n_checks++; if (q !== 32'h0 || r !== 32'h80000000) begin n_fail++; $display("FAIL ovf_unsigned got q=%h r=%h exp q=0 r=80000000", q, r); end
    retire();
    run_op(1'b1, 32'h80000000, 32'd2, lat, q, r, z);
    n_checks++; if (q !== 32'hC0000000 || r !== 32'h0) begin n_fail++; $display("FAIL min_by_two got q=%h r=%h exp q=c0000000 r=0", q, r); end
    retire();
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] q, r; logic z;
    run_op(1'b0, 32'h12345678, 32'h0, lat, q, r, z);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    n_checks++; if (q !== 32'hFFFFFFFF || r !== 32'h12345678) begin n_fail++; $display("FAIL dbz_values got q=%h r=%h exp q=ffffffff r=12345678", q, r); end
    n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got=%0b exp=1", z); end
    retire();
    run_op(1'b1, 32'h80000001, 32'h0, lat, q, r, z);
    n_checks++; if (q !== 32'hFFFFFFFF || r !== 32'h80000001 || z !== 1'b1) begin n_fail++; $display("FAIL dbz_signed got q=%h r=%h z=%0b exp q=ffffffff r=80000001 z=1", q, r, z); end
    retire();
    run_op(1'b0, 32'd9, 32'd3, lat, q, r, z);
    n_checks++; if (z !== 1'b0 || q !== 32'd3) begin n_fail++; $display("FAIL dbz_cleared got q=%h z=%0b exp q=3 z=0", q, z); end
    retire();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] q, r; logic z;
    int bad;
    run_op(1'b0, 32'd1000, 32'd3, lat, q, r, z);
    n_checks++; if (q !== 32'd333 || r !== 32'd1) begin n_fail++; $display("FAIL b2b_first got q=%h r=%h exp q=14d r=1", q, r); end
    in_signed = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    in_valid  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd333 || remainder !== 32'd1 || div_by_zero !== 1'b0) bad++;
      @(posedge aclk); #1;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_hold got %0d unstable cycles exp 0", bad); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    @(posedge aclk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    dividend  = 32'd77;
    divisor   = 32'd1;
    n_checks++; if (out_valid !== 1'b0 || dbg_state !== PREP) begin n_fail++; $display("FAIL b2b_accept got valid=%0b state=%0d exp valid=0 state=%0d", out_valid, dbg_state, PREP); end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge aclk); #1;
      if (out_valid) begin lat = n; break; end
    end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
    n_checks++; if (quotient !== 32'd10 || remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_second got q=%h r=%h exp q=a r=0", quotient, remainder); end
    retire();
  endtask

  task automatic test_flush();
    int lat; logic [31:0] q, r; logic z;
    int seen;
    in_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    in_valid  = 1'b1;
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    n_checks++; if (dbg_state !== ITER) begin n_fail++; $display("FAIL flush_pre_state got=%0d exp=%0d", dbg_state, ITER); end
    flush    = 1'b1;
    in_valid = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    @(posedge aclk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (dbg_state !== IDLE || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle got state=%0d valid=%0b exp state=%0d valid=0", dbg_state, out_valid, IDLE); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_result got %0d valid cycles exp 0", seen); end
    run_op(1'b0, 32'd200, 32'd9, lat, q, r, z);
    n_checks++; if (q !== 32'd22 || r !== 32'd2 || lat !== 34) begin n_fail++; $display("FAIL flush_next got q=%h r=%h lat=%0d exp q=16 r=2 lat=34", q, r, lat); end
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge aclk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL flush_done got valid=%0b state=%0d exp valid=0 state=%0d", out_valid, dbg_state, IDLE); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] q, r; logic z;
    in_signed = 1'b1;
    dividend  = 32'hFFFFFF9C;
    divisor   = 32'd7;
    in_valid  = 1'b1;
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge aclk);
    #3 areset = 1'b1;
    #1;
    n_checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin n_fail++; $display("FAIL areset_data got q=%h r=%h exp 0 0", quotient, remainder); end
    n_checks++; if (out_valid !== 1'b0 || div_by_zero !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL areset_ctrl got valid=%0b dbz=%0b state=%0d exp 0 0 %0d", out_valid, div_by_zero, dbg_state, IDLE); end
    @(negedge aclk);
    areset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_release_ready got=%0b exp=1", in_ready); end
    @(posedge aclk); #1;
    run_op(1'b0, 32'd9, 32'd3, lat, q, r, z);
    n_checks++; if (q !== 32'd3 || r !== 32'd0 || lat !== 34) begin n_fail++; $display("FAIL areset_next got q=%h r=%h lat=%0d exp q=3 r=0 lat=34", q, r, lat); end
    retire();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    areset    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
